// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate cache controller with
//   integrated tag, valid and data arrays. Read hits and all writes complete
//   in the cycle they are presented. A read miss stalls the CPU while one line
//   is fetched from a pipelined main memory with fixed read latency.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   cpu_req    in   CPU access request this cycle
//   cpu_we     in   1 = write, 0 = read
//   cpu_addr   in   byte address (bit 0 ignored)
//   cpu_wdata  in   CPU write data
//   cpu_rdata  out  read data, non-zero only on a read hit
//   stall      out  CPU must freeze and hold its request
//   mem_en     out  memory request strobe
//   mem_we     out  memory write enable
//   mem_addr   out  memory byte address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data
//   mem_valid  in   mem_rdata valid this cycle
module dm_cache_ctrl #(
    parameter int unsigned LINES       = 64,
    parameter int unsigned WORDS       = 8,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned OFF_W   = $clog2(WORDS);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = 15 - OFF_W - IDX_W;
    localparam int unsigned IDX_LSB = OFF_W + 1;
    localparam int unsigned TAG_LSB = OFF_W + IDX_W + 1;
    localparam logic [15:0] LINE_MASK = 16'(WORDS * 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WAIT
    } state_t;

    state_t                   state_q;
    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [15:0]              data_q [LINES*WORDS];

    logic [15:0]              base_q;
    logic [IDX_W-1:0]         fidx_q;
    logic [TAG_W-1:0]         ftag_q;
    logic [OFF_W-1:0]         icnt_q;
    logic [OFF_W-1:0]         rcnt_q;
    logic [MEM_LATENCY-1:0]   pipe_q;

    logic [OFF_W-1:0]         off;
    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic                     idle;
    logic                     hit;
    logic                     rd_hit;
    logic                     rd_miss;
    logic                     wr;
    logic                     wr_hit;
    logic                     beat;
    logic                     last_beat;
    logic                     unused_addr0;

    assign unused_addr0 = cpu_addr[0];

    assign off  = cpu_addr[OFF_W:1];
    assign idx  = cpu_addr[TAG_LSB-1:IDX_LSB];
    assign tag  = cpu_addr[15:TAG_LSB];
    assign idle = (state_q == S_IDLE);
    assign hit  = cpu_req & valid_q[idx] & (tag_q[idx] == tag);

    assign rd_hit  = idle & hit & ~cpu_we;
    assign rd_miss = idle & cpu_req & ~cpu_we & ~hit;
    assign wr      = idle & cpu_req & cpu_we;
    assign wr_hit  = wr & hit;

    // pipe_q tracks which cycles issued a fill read; a returning beat is only
    // accepted when it lines up with one of our own issues, so beats still in
    // flight from a fill aborted by reset never land in the arrays.
    assign beat      = mem_valid & pipe_q[MEM_LATENCY-1] & ~idle;
    assign last_beat = beat & (rcnt_q == '1);

    always_comb begin
        cpu_rdata = '0;
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_hit) begin
            cpu_rdata = data_q[{idx, off}];
        end
        if (rd_miss || !idle) begin
            stall = 1'b1;
        end
        if (wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (state_q == S_FILL) begin
            mem_en   = 1'b1;
            mem_addr = base_q + 16'({icnt_q, 1'b0});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            base_q  <= '0;
            fidx_q  <= '0;
            ftag_q  <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            pipe_q  <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | MEM_LATENCY'(state_q == S_FILL);
            case (state_q)
                S_IDLE: begin
                    if (rd_miss) begin
                        base_q       <= cpu_addr & ~LINE_MASK;
                        fidx_q       <= idx;
                        ftag_q       <= tag;
                        icnt_q       <= '0;
                        rcnt_q       <= '0;
                        // the line is being overwritten, so it must not look
                        // valid until every word of the new line is in place
                        valid_q[idx] <= 1'b0;
                        state_q      <= S_FILL;
                    end
                end
                S_FILL: begin
                    icnt_q <= icnt_q + 1'b1;
                    if (icnt_q == '1) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (beat) begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            if (last_beat) begin
                valid_q[fidx_q] <= 1'b1;
                state_q         <= S_IDLE;
            end
        end
    end

    // Tag and data storage carry no reset; validity is governed by valid_q.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_q[{fidx_q, rcnt_q}] <= mem_rdata;
        end else if (wr_hit) begin
            data_q[{idx, off}] <= cpu_wdata;
        end
        if (last_beat) begin
            tag_q[fidx_q] <= ftag_q;
        end
    end

endmodule
